// File: rtl/motoro3_pkg.sv
// Shared motor-control definitions: capture FSM encoding, counter width default
// and the system clock constant used by both the PWM generator and the capture block.
package motoro3_pkg;

    localparam int CNT_W_DEF    = 13;
    localparam int FILT_LEN_DEF = 3;
    localparam int CLK_FREQ_HZ  = 10_000_000;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } cap_state_e;

endpackage

// File: rtl/motoro3_pwm_capture_sync.sv
// Two-flop synchronizer for the PWM input, followed by an optional glitch filter
// (compiled in with MOTORO3_PWM_CAP_GLITCH_FILTER_EN). Output is the conditioned level.
module motoro3_pwm_capture_sync
    import motoro3_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic nRst,
    input  logic pwm_in,
    output logic level
);

    logic [1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pwm_in};
        end
    end

`ifdef MOTORO3_PWM_CAP_GLITCH_FILTER_EN
    localparam int RUN_W = $clog2(FILT_LEN + 1);

    logic [RUN_W-1:0] run;
    logic             filt;

    // run counts consecutive samples disagreeing with the filtered level.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            run  <= '0;
            filt <= 1'b0;
        end else if (sync_q[1] == filt) begin
            run <= '0;
        end else if (run == RUN_W'(FILT_LEN - 1)) begin
            filt <= sync_q[1];
            run  <= '0;
        end else begin
            run <= run + RUN_W'(1);
        end
    end

    assign level = filt;
`else
    // Filter length only matters when the filter is compiled in.
    localparam int unused_filt_len = FILT_LEN;

    assign level = sync_q[1];
`endif

endmodule

// File: rtl/motoro3_pwm_capture.sv
// PWM capture: measures on/off time and period of a gate-drive waveform and flags
// stuck-high/stuck-low drive. Optional glitch filter: MOTORO3_PWM_CAP_GLITCH_FILTER_EN.
module motoro3_pwm_capture
    import motoro3_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             pwmIn,
    input  logic             captureEn,
    output logic [CNT_W-1:0] onTime,
    output logic [CNT_W-1:0] offTime,
    output logic [CNT_W:0]   period,
    output logic             capValid,
    output logic             stuckHigh,
    output logic             stuckLow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             pwm_s;
    logic             pwm_d;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] on_acc;
    cap_state_e       state;

    motoro3_pwm_capture_sync #(
        .FILT_LEN (FILT_LEN)
    ) u_sync (
        .clk    (clk),
        .nRst   (nRst),
        .pwm_in (pwmIn),
        .level  (pwm_s)
    );

    assign rise    = pwm_s & ~pwm_d;
    assign fall    = ~pwm_s & pwm_d;
    assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;

    // pwm_d keeps tracking while disabled so a level already high at re-enable is not seen as an edge.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= S_WAIT;
            pwm_d     <= 1'b0;
            cnt       <= '0;
            on_acc    <= '0;
            onTime    <= '0;
            offTime   <= '0;
            period    <= '0;
            capValid  <= 1'b0;
            stuckHigh <= 1'b0;
            stuckLow  <= 1'b0;
        end else begin
            pwm_d    <= pwm_s;
            capValid <= 1'b0;
            if (!captureEn) begin
                state     <= S_WAIT;
                cnt       <= '0;
                on_acc    <= '0;
                stuckHigh <= 1'b0;
                stuckLow  <= 1'b0;
            end else begin
                case (state)
                    S_WAIT: begin
                        if (rise) begin
                            cnt   <= CNT_ONE;
                            state <= S_HIGH;
                        end
                    end
                    S_HIGH: begin
                        if (fall) begin
                            on_acc    <= cnt;
                            cnt       <= CNT_ONE;
                            stuckHigh <= 1'b0;
                            state     <= S_LOW;
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_inc == CNT_MAX) stuckHigh <= 1'b1;
                        end
                    end
                    S_LOW: begin
                        if (rise) begin
                            onTime   <= on_acc;
                            offTime  <= cnt;
                            period   <= {1'b0, on_acc} + {1'b0, cnt};
                            capValid <= 1'b1;
                            stuckLow <= 1'b0;
                            cnt      <= CNT_ONE;
                            state    <= S_HIGH;
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_inc == CNT_MAX) stuckLow <= 1'b1;
                        end
                    end
                    default: state <= S_WAIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_motoro3_pwm_capture.sv
// Self-checking bench for motoro3_pwm_capture: scoreboard of expected captures
// popped on every capValid, plus per-scenario inline checks of the stuck flags and holds.
`timescale 1ns/1ps
module tb_motoro3_pwm_capture;

    localparam int CNT_W = 13;

    typedef struct {
        logic [CNT_W-1:0] on;
        logic [CNT_W-1:0] off;
        logic [CNT_W:0]   per;
    } cap_t;

    logic             clk = 1'b0;
    logic             nRst = 1'b0;
    logic             pwmIn = 1'b0;
    logic             captureEn = 1'b0;
    logic [CNT_W-1:0] onTime;
    logic [CNT_W-1:0] offTime;
    logic [CNT_W:0]   period;
    logic             capValid;
    logic             stuckHigh;
    logic             stuckLow;

    cap_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    logic prev_valid = 1'b0;

    motoro3_pwm_capture #(
        .CNT_W    (CNT_W),
        .FILT_LEN (3)
    ) dut (
        .clk       (clk),
        .nRst      (nRst),
        .pwmIn     (pwmIn),
        .captureEn (captureEn),
        .onTime    (onTime),
        .offTime   (offTime),
        .period    (period),
        .capValid  (capValid),
        .stuckHigh (stuckHigh),
        .stuckLow  (stuckLow)
    );

    always #50 clk = ~clk;

    // Scoreboard: every capture strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (nRst === 1'b1 && capValid === 1'b1) begin
            checks++;
            if (prev_valid === 1'b1) begin
                errors++;
                $display("FAIL cap_consecutive got capValid high two cycles expected single strobe");
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cap_unexpected got on=%0d off=%0d per=%0d expected no capture",
                         onTime, offTime, period);
            end else begin
                cap_t e;
                e = exp_q.pop_front();
                if ({onTime, offTime, period} !== {e.on, e.off, e.per}) begin
                    errors++;
                    $display("FAIL cap_data got on=%0d off=%0d per=%0d expected on=%0d off=%0d per=%0d",
                             onTime, offTime, period, e.on, e.off, e.per);
                end
            end
        end
        prev_valid = capValid;
    end

    task automatic hold(input logic v, input int n);
        pwmIn = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int on, input int off);
        cap_t e;
        e.on  = CNT_W'(on);
        e.off = CNT_W'(off);
        e.per = (CNT_W + 1)'(on + off);
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got pending=%0d expected pending=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic idle();
        pwmIn     = 1'b0;
        captureEn = 1'b0;
        repeat (6) @(negedge clk);
        captureEn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        captureEn = 1'b0;
        pwmIn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({onTime, offTime, period} !== '0) begin
            errors++;
            $display("FAIL reset_data got on=%0d off=%0d per=%0d expected 0", onTime, offTime, period);
        end
        checks++;
        if ({capValid, stuckHigh, stuckLow} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b expected 000", {capValid, stuckHigh, stuckLow});
        end
        nRst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_main();
        idle();
        hold(1'b1, 32);
        repeat (3) begin
            hold(1'b0, 4063);
            push_exp(32, 4063);
            hold(1'b1, 32);
        end
        drain("main");
        checks++;
        if ({onTime, offTime, period} !== {13'd32, 13'd4063, 14'd4095}) begin
            errors++;
            $display("FAIL main_hold got on=%0d off=%0d per=%0d expected on=32 off=4063 per=4095",
                     onTime, offTime, period);
        end
    endtask

    task automatic test_stuck();
        idle();
        hold(1'b1, 8000);
        checks++;
        if (stuckHigh !== 1'b0) begin
            errors++;
            $display("FAIL stuck_high_early got %b expected 0", stuckHigh);
        end
        hold(1'b1, 1000);
        checks++;
        if ({stuckHigh, stuckLow} !== 2'b10) begin
            errors++;
            $display("FAIL stuck_high_set got high=%b low=%b expected high=1 low=0", stuckHigh, stuckLow);
        end
        push_exp(8191, 8191);
        hold(1'b0, 10);
        checks++;
        if (stuckHigh !== 1'b0) begin
            errors++;
            $display("FAIL stuck_high_clear got %b expected 0", stuckHigh);
        end
        hold(1'b0, 7990);
        checks++;
        if (stuckLow !== 1'b0) begin
            errors++;
            $display("FAIL stuck_low_early got %b expected 0", stuckLow);
        end
        hold(1'b0, 1000);
        checks++;
        if ({stuckHigh, stuckLow} !== 2'b01) begin
            errors++;
            $display("FAIL stuck_low_set got high=%b low=%b expected high=0 low=1", stuckHigh, stuckLow);
        end
        hold(1'b1, 10);
        checks++;
        if (stuckLow !== 1'b0) begin
            errors++;
            $display("FAIL stuck_low_clear got %b expected 0", stuckLow);
        end
        drain("stuck");
    endtask

    task automatic test_capture_en();
        idle();
        hold(1'b1, 25);
        hold(1'b0, 30);
        push_exp(25, 30);
        hold(1'b1, 20);
        drain("en_first");
        captureEn = 1'b0;
        hold(1'b1, 10);
        checks++;
        if ({onTime, offTime, period} !== {13'd25, 13'd30, 14'd55}) begin
            errors++;
            $display("FAIL en_hold got on=%0d off=%0d per=%0d expected on=25 off=30 per=55",
                     onTime, offTime, period);
        end
        checks++;
        if ({stuckHigh, stuckLow} !== 2'b00) begin
            errors++;
            $display("FAIL en_flags got %b expected 00", {stuckHigh, stuckLow});
        end
        captureEn = 1'b1;
        hold(1'b1, 10);
        hold(1'b0, 30);
        hold(1'b1, 40);
        hold(1'b0, 50);
        push_exp(40, 50);
        hold(1'b1, 10);
        drain("en_after");
    endtask

    task automatic test_reset_mid();
        idle();
        hold(1'b1, 25);
        hold(1'b0, 35);
        push_exp(25, 35);
        hold(1'b1, 25);
        drain("rst_before");
        hold(1'b0, 10);
        nRst = 1'b0;
        #1;
        checks++;
        if ({onTime, offTime, period, capValid, stuckHigh, stuckLow} !== '0) begin
            errors++;
            $display("FAIL rst_mid got on=%0d off=%0d per=%0d flags=%b expected all 0",
                     onTime, offTime, period, {capValid, stuckHigh, stuckLow});
        end
        repeat (3) @(negedge clk);
        nRst = 1'b1;
        hold(1'b0, 20);
        hold(1'b1, 15);
        hold(1'b0, 17);
        push_exp(15, 17);
        hold(1'b1, 10);
        drain("rst_after");
    endtask

`ifdef MOTORO3_PWM_CAP_GLITCH_FILTER_EN
    task automatic test_filter();
        idle();
        hold(1'b1, 50);
        hold(1'b0, 2);
        hold(1'b1, 48);
        hold(1'b0, 3);
        push_exp(100, 3);
        hold(1'b1, 60);
        hold(1'b0, 70);
        push_exp(60, 70);
        hold(1'b1, 10);
        drain("filter");
    endtask
`else
    task automatic test_back_to_back();
        idle();
        hold(1'b1, 1);
        repeat (10) begin
            hold(1'b0, 1);
            push_exp(1, 1);
            hold(1'b1, 1);
        end
        hold(1'b1, 5);
        drain("b2b");
    endtask
`endif

    initial begin
        test_reset();
        test_main();
        test_stuck();
        test_capture_en();
        test_reset_mid();
`ifdef MOTORO3_PWM_CAP_GLITCH_FILTER_EN
        test_filter();
`else
        test_back_to_back();
`endif
        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/motoro3_pwm_capture.md
# motoro3_pwm_capture

Measures an incoming PWM/chopper waveform (the gate drive produced by the three-phase motor PWM generator, or an external driver's feedback) and reports on-time, off-time and period in clk cycles. It sits on the motor-control verification/feedback path, so the commutation logic can confirm the duty actually reaching the MOSFETs. It also detects stuck-high and stuck-low gate drive, which catches lost sub-3 µs pulses.

## Interface
Parameters:
- CNT_W, 13: width of the on/off counters; period is CNT_W+1 bits.
- FILT_LEN, 3: number of consecutive equal samples required by the glitch filter. Used only when the filter is compiled in.

Ports:
- clk  input  1  10 MHz system clock; all logic on posedge.
- nRst  input  1  reset, asynchronous, active-low.
- pwmIn  input  1  asynchronous PWM input.
- captureEn  input  1  enables measurement; low forces idle.
- onTime  output  CNT_W  cycles high in the last complete period.
- offTime  output  CNT_W  cycles low in the last complete period.
- period  output  CNT_W+1  onTime+offTime, zero-extended sum, no overflow possible.
- capValid  output  1  one-cycle strobe; new onTime/offTime/period valid.
- stuckHigh  output  1  high level has lasted ≥ 2^CNT_W−1 cycles.
- stuckLow  output  1  low level has lasted ≥ 2^CNT_W−1 cycles.

## Operation
- Input conditioning:
  - pwmIn passes through a 2-flop synchronizer, reset value 0, giving pwmS.
  - Edge detection compares pwmS with its registered copy pwmD.
- FSM states: S_WAIT, S_HIGH, S_LOW. Reset state is S_WAIT.
- S_WAIT:
  - Ignore levels; wait for a rising edge.
  - On a rising edge: cnt←1, go to S_HIGH. The first partial period is never reported.
- S_HIGH:
  - Each cycle with no edge: cnt←cnt+1, saturating at all-ones.
  - When cnt reaches all-ones: stuckHigh←1.
  - On a falling edge: onAcc←cnt, cnt←1, stuckHigh←0, go to S_LOW.
- S_LOW:
  - Each cycle with no edge: cnt increments and saturates as in S_HIGH.
  - When cnt reaches all-ones: stuckLow←1.
  - On a rising edge:
    - onTime←onAcc, offTime←cnt, period←onAcc+cnt.
    - capValid←1 for exactly one cycle; stuckLow←0.
    - cnt←1, go to S_HIGH.
- Saturated values are reported as all-ones, never wrapped.
- captureEn low, sampled each cycle:
  - Next state S_WAIT; cnt, onAcc and the stuck flags clear.
  - capValid stays 0.
  - onTime/offTime/period hold their last values.
  - captureEn has priority over a simultaneous edge.
- captureEn rising: the block behaves as if just reset, except the data outputs retain their values.
- Reset values: onTime=0, offTime=0, period=0, capValid=0, stuckHigh=0, stuckLow=0, cnt=0, onAcc=0.
- Reset mid-period discards all partial counts.

## Timing
- Without the filter, a pwmIn transition at clock edge k produces an edge detect at edge k+3.
  - The capValid strobe and updated data outputs are registered at edge k+3 after the closing rising input.
- With the filter compiled in, add FILT_LEN cycles of latency.
- Minimum resolvable pulse:
  - 1 cycle level at pwmS without the filter.
  - FILT_LEN cycles with the filter; shorter pulses are suppressed entirely.
- Back-to-back periods: capValid may assert every on+off cycles; no dead cycle is required between captures.
- All outputs change only on posedge clk; capValid never asserts for two consecutive cycles.

## Configuration
- MOTORO3_PWM_CAP_GLITCH_FILTER_EN
- Defined:
  - A filter sits between the synchronizer and edge detect.
  - The filtered level changes only after FILT_LEN consecutive equal pwmS samples.
  - The filter state resets to 0.
- Undefined: the filtered level equals pwmS directly and FILT_LEN is unused.

## Structure
- Shared package motoro3_pkg holds:
  - the FSM state encoding (S_WAIT=2'd0, S_HIGH=2'd1, S_LOW=2'd2);
  - the CNT_W default;
  - the 10 MHz clock constant shared with the PWM generator.
- One sub-module, motoro3_pwm_capture_sync: synchronizer plus optional glitch filter, with the filtered level as its output.
- The FSM, counters and output registers live in the top module.

## Test plan
- Drive pwmIn 32 cycles high / 4063 low, repeated, captureEn=1 → from the second rising edge, capValid each period with onTime=32, offTime=4063, period=4095.
- Hold pwmIn high 9000 cycles after a rising edge → stuckHigh=1 from 8191 cycles after the edge. On the falling edge stuckHigh=0, and the next capture reports onTime=8191.
- Drop captureEn for 10 cycles mid-high-phase → no capValid and outputs hold. After re-enable, the first capValid appears only after one full period following the next rising edge.
- Assert nRst mid-low-phase → all outputs 0 immediately. The first capture after release comes after the second rising edge.
- Filter compiled in with FILT_LEN=3: 2-cycle low glitch inside a 100-cycle high → ignored, onTime=100. A 3-cycle low pulse → captured, offTime=3.
- Pulse stream 1 high / 1 low without the filter → capValid every 2 cycles, onTime=1, offTime=1, period=2.
